keypad_code_entry: RTL
======================

Name: keypad_code_entry

Overview:
- Upstream feeder for the 16-bit serial password checker.
- Collects decimal digits from a keypad decoder via a valid/ready handshake and supports clear and backspace.
- On ENTER, converts the digits to a binary code (e.g. 5938 -> 16'h1732) over DIGITS cycles.
- Presents the code to the checker stable for HOLD_CYCLES and pulses the checker's reset so it re-evaluates from its first state.

Parameters:
DIGITS, 4, number of decimal digits per code; max 4 so 9999 fits in 14 bits
HOLD_CYCLES, 20, cycles code is held stable after arming; must be >= 17 (checker needs 16 bit-steps + 1)
TIMEOUT_CYCLES, 1000, idle cycles in ENTRY before the partial entry is discarded
TMR_W, 10, timer width; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
key_valid  in  1  key_code valid this cycle
key_code  in  4  0-9 digit, 4'hA clear, 4'hB backspace, 4'hE enter; other values are accepted and discarded
key_ready  out  1  block accepts a key; transfer = key_valid & key_ready
code  out  16  binary code to checker; idle value 16'hFFFF
checker_rst  out  1  one-cycle restart pulse to checker
code_hold  out  1  high while code is being presented
digit_count  out  3  digits currently buffered (0..DIGITS)
entry_error  out  1  one-cycle pulse on rejected entry or timeout

Behaviour:
- Reset values: state IDLE, code 16'hFFFF, checker_rst 0, code_hold 0, digit_count 0, entry_error 0, all digit buffer entries 0, timer 0.
- key_ready is decoded from state: 1 in IDLE/ENTRY (including during rst), 0 in CONVERT/ARM/PRESENT.
- IDLE (digit_count=0):
  - digit -> buf[0]; count becomes 1; go to ENTRY.
  - CLEAR and BACKSPACE: no effect.
  - ENTER: entry_error pulse; stay in IDLE.
- ENTRY:
  - digit with count<DIGITS: buf[count] <= d; count++.
  - digit with count==DIGITS: ignored; entry_error pulse.
  - BACKSPACE: count--; if count becomes 0, go to IDLE.
  - CLEAR: count <= 0; go to IDLE.
  - ENTER with count==DIGITS: go to CONVERT. Any other count: entry_error pulse, count <= 0, go to IDLE.
  - Timer: restarts on every accepted key. When it reaches TIMEOUT_CYCLES-1 with no key: entry_error pulse, count <= 0, go to IDLE. A key accepted in that same cycle wins (timer restarts, no timeout).
- CONVERT: exactly DIGITS cycles, idx 0..DIGITS-1, acc <= acc*10 + buf[idx], with acc cleared on entry. Digits are processed most-significant first; multiply by 10 is done as (acc<<3)+(acc<<1). acc is 14 bits and zero-extended to 16.
- ARM: 1 cycle.
  - code <= acc is registered at the CONVERT->ARM edge, so code is valid during the ARM cycle.
  - checker_rst=1 in ARM only.
- PRESENT: code_hold=1 for exactly HOLD_CYCLES cycles; code is constant throughout.
  - Then go to IDLE: code <= 16'hFFFF (bit15=1 keeps checker parked in its first state), count <= 0.
- Latency: 1 cycle from ENTER accepted to CONVERT, DIGITS cycles in CONVERT, then the ARM cycle and the checker_rst pulse.
- entry_error is registered: it is high in the cycle after the offending key or timeout and never lasts more than 1 cycle.
- digit_count is registered and reflects accepted keys one cycle after the handshake.
- Reset mid-operation (any state, including PRESENT): all outputs return to reset values immediately; the entry is lost.
- Reset never generates checker_rst; the checker has its own rst.

Decomposition:
- Shared package: key code constants (KEY_CLEAR=4'hA, KEY_BKSP=4'hB, KEY_ENTER=4'hE), state encoding (IDLE, ENTRY, CONVERT, ARM, PRESENT), IDLE_CODE=16'hFFFF.
- One sub-module: bcd_accum, a 14-bit acc*10+digit datapath register with clear/enable, owned by CONVERT.

Test Plan:
- Keys 5,9,3,8,ENTER -> 4 CONVERT cycles; code=16'h1732 in ARM with checker_rst=1 for 1 cycle; code_hold=1 for 20 cycles; then code=16'hFFFF, digit_count=0.
- Keys 5,9,7,BKSP,3,8,ENTER -> code=16'h1732; digit_count sequence 1,2,3,2,3,4.
- Keys 5,9,ENTER -> entry_error 1 cycle, digit_count=0, no checker_rst, code stays 16'hFFFF. Keys 5,9,3,8,1 -> entry_error, digit_count stays 4; then ENTER -> code=16'h1732.
- Keys 9,9,9,9,ENTER -> code=16'h270F. Keys 0,0,0,0,ENTER -> code=16'h0000. key_valid held high during CONVERT/PRESENT -> no key accepted (key_ready=0).
- Keys 5,9 then no key for 1000 cycles -> entry_error pulse, digit_count=0. A key accepted on cycle 999 -> no timeout.
- rst asserted mid-PRESENT -> code=16'hFFFF, code_hold=0, key_ready=1 immediately. A following full 5938 entry works normally.

Source files
------------

// File: rtl/keypad_code_entry_pkg.sv
// Shared definitions for the keypad code entry block.
//   - Key code constants produced by the keypad decoder.
//   - FSM state encoding.
//   - Idle value driven to the password checker (bit 15 set parks it).
package keypad_code_entry_pkg;

  localparam logic [3:0]  KEY_CLEAR = 4'hA;
  localparam logic [3:0]  KEY_BKSP  = 4'hB;
  localparam logic [3:0]  KEY_ENTER = 4'hE;

  localparam logic [15:0] IDLE_CODE = 16'hFFFF;

  // 9999 is the largest 4-digit value and fits in 14 bits.
  localparam int ACC_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CONVERT,
    ARM,
    PRESENT
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_code_entry_if.sv
// Bus between the keypad decoder, the code entry block and the password
// checker.
//   key_valid/key_code/key_ready : key handshake from the keypad decoder
//   code/checker_rst/code_hold   : code presentation to the checker
//   digit_count/entry_error      : status for the user interface
// The slave modport is the code entry block; master is its environment.
interface keypad_code_entry_if;

  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [15:0] code;
  logic        checker_rst;
  logic        code_hold;
  logic [2:0]  digit_count;
  logic        entry_error;

  modport master (
    output key_valid, key_code,
    input  key_ready, code, checker_rst, code_hold, digit_count, entry_error
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, code, checker_rst, code_hold, digit_count, entry_error
  );

endinterface

// File: rtl/keypad_code_entry_bcd_accum.sv
// bcd_accum: decimal-to-binary accumulator, acc <= acc*10 + digit.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : load zero (takes priority over en)
//   en        : accumulate one digit
//   digit     : decimal digit 0..9
//   acc_next  : value the register takes at the next edge; the owner uses
//               it to capture the final result at the same edge as the last
//               accumulation step.
module bcd_accum
  import keypad_code_entry_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_next
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] times_ten;

  // x*10 as x*8 + x*2; no multiplier needed.
  assign times_ten = {acc_reg[ACC_W-4:0], 3'b000} + {acc_reg[ACC_W-2:0], 1'b0};

  always_comb begin
    acc_next = acc_reg;
    if (clr)     acc_next = '0;
    else if (en) acc_next = times_ten + {{(ACC_W-4){1'b0}}, digit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_reg <= '0;
    else     acc_reg <= acc_next;
  end

endmodule

// File: rtl/keypad_code_entry.sv
// keypad_code_entry: collects decimal digits from a keypad decoder, converts
// a complete entry to binary and presents it to the serial password checker.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of keypad_code_entry_if
//              key_valid/key_code/key_ready - key handshake
//              code        - binary code to checker (IDLE_CODE when idle)
//              checker_rst - one-cycle restart pulse to checker (ARM state)
//              code_hold   - high while the code is being presented
//              digit_count - digits currently buffered
//              entry_error - one-cycle pulse on rejected entry or timeout
module keypad_code_entry
  import keypad_code_entry_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int HOLD_CYCLES    = 20,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input logic                clk,
  input logic                rst,
  keypad_code_entry_if.slave bus
);

  state_t             state_reg, state_next;
  logic [2:0]         count_reg, count_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic [1:0]         idx_reg, idx_next;
  logic [15:0]        code_reg, code_next;
  logic               error_reg, error_next;
  logic               checker_rst_reg;
  logic               hold_reg;

  logic               key_ready;
  logic               key_fire;
  logic               buf_we;
  logic               acc_clr;
  logic               acc_en;
  logic [3:0]         digit_sel;
  logic [ACC_W-1:0]   acc_next;
  logic [4*DIGITS-1:0] buf_flat;

  assign key_ready = (state_reg == IDLE) || (state_reg == ENTRY);
  assign key_fire  = bus.key_valid && key_ready;

  // Digit buffer: entry gi is written when a digit arrives while gi digits
  // are already held.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_buf
    logic [3:0] digit_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  digit_reg <= '0;
      else if (buf_we && count_reg == 3'(gi))   digit_reg <= bus.key_code;
    end
    assign buf_flat[4*gi +: 4] = digit_reg;
  end

  // Buffer entry 0 holds the most significant digit, so CONVERT walks up.
  always_comb begin
    digit_sel = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_reg == 2'(i)) digit_sel = buf_flat[4*i +: 4];
  end

  bcd_accum u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .en       (acc_en),
    .digit    (digit_sel),
    .acc_next (acc_next)
  );

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    timer_next = timer_reg;
    idx_next   = idx_reg;
    code_next  = code_reg;
    error_next = 1'b0;
    buf_we     = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (key_fire) begin
          if (is_digit(bus.key_code)) begin
            buf_we     = 1'b1;
            count_next = 3'd1;
            timer_next = '0;
            state_next = ENTRY;
          end else if (bus.key_code == KEY_ENTER) begin
            error_next = 1'b1;
          end
        end
      end

      ENTRY: begin
        if (key_fire) begin
          // Any accepted key, even a discarded code, counts as activity.
          timer_next = '0;
          if (is_digit(bus.key_code)) begin
            if (count_reg < 3'(DIGITS)) begin
              buf_we     = 1'b1;
              count_next = count_reg + 3'd1;
            end else begin
              error_next = 1'b1;
            end
          end else if (bus.key_code == KEY_BKSP) begin
            count_next = count_reg - 3'd1;
            if (count_reg == 3'd1) state_next = IDLE;
          end else if (bus.key_code == KEY_CLEAR) begin
            count_next = '0;
            state_next = IDLE;
          end else if (bus.key_code == KEY_ENTER) begin
            if (count_reg == 3'(DIGITS)) begin
              acc_clr    = 1'b1;
              idx_next   = '0;
              state_next = CONVERT;
            end else begin
              error_next = 1'b1;
              count_next = '0;
              state_next = IDLE;
            end
          end
        end else if (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          error_next = 1'b1;
          count_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      CONVERT: begin
        acc_en = 1'b1;
        if (idx_reg == 2'(DIGITS - 1)) begin
          // Capture the post-accumulate value so code is valid during ARM.
          code_next  = {2'b00, acc_next};
          state_next = ARM;
        end else begin
          idx_next = idx_reg + 2'd1;
        end
      end

      ARM: begin
        timer_next = '0;
        state_next = PRESENT;
      end

      PRESENT: begin
        if (timer_reg == TMR_W'(HOLD_CYCLES - 1)) begin
          code_next  = IDLE_CODE;
          count_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      timer_reg       <= '0;
      idx_reg         <= '0;
      code_reg        <= IDLE_CODE;
      error_reg       <= 1'b0;
      checker_rst_reg <= 1'b0;
      hold_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      timer_reg       <= timer_next;
      idx_reg         <= idx_next;
      code_reg        <= code_next;
      error_reg       <= error_next;
      // Registered from the next state so the checker sees clean pulses.
      checker_rst_reg <= (state_next == ARM);
      hold_reg        <= (state_next == PRESENT);
    end
  end

  assign bus.key_ready   = key_ready;
  assign bus.code        = code_reg;
  assign bus.checker_rst = checker_rst_reg;
  assign bus.code_hold   = hold_reg;
  assign bus.digit_count = count_reg;
  assign bus.entry_error = error_reg;

endmodule
